// File: rtl/chord_sched_pkg.sv
// Shared widths and FSM state type for the chord scheduler.
package chord_sched_pkg;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;
endpackage

// File: rtl/chord_scheduler_if.sv
// Note-request handshake between a sequencer (master) and the scheduler (slave).
interface chord_scheduler_if;
  import chord_sched_pkg::*;

  logic              req_valid;
  logic [NOTE_W-1:0] req_note;
  logic [DUR_W-1:0]  req_duration;
  logic              req_ready;

  modport master (output req_valid, req_note, req_duration, input req_ready);
  modport slave  (input req_valid, req_note, req_duration, output req_ready);
endinterface

// File: rtl/chord_slot_picker.sv
// Combinational free-slot selection: round-robin over done slots, or (CHORD_STEAL_EN)
// fall back to the slot with the largest elapsed count when none is done.
module chord_slot_picker
  import chord_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 3,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0]       slot_done,
  input  logic [DUR_W*NUM_SLOTS-1:0] slot_elapsed,
  input  logic [IDX_W-1:0]           rr_ptr,
  output logic [IDX_W-1:0]           target,
  output logic                       available
);
  logic [NUM_SLOTS-1:0] w_hit;
  logic [IDX_W-1:0]     w_rr_idx;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_hit
    assign w_hit[gi] = slot_done[gi] && (IDX_W'(gi) >= rr_ptr);
  end

  // Descending scans so the lowest index wins; the at-or-above-pointer pass overrides the wrap pass.
  always_comb begin
    w_rr_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (slot_done[i]) w_rr_idx = IDX_W'(i);
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (w_hit[i]) w_rr_idx = IDX_W'(i);
  end

`ifdef CHORD_STEAL_EN
  logic [IDX_W-1:0] w_max_idx;
  logic [DUR_W-1:0] w_max_val;

  always_comb begin
    w_max_idx = '0;
    w_max_val = slot_elapsed[DUR_W-1:0];
    for (int i = 1; i < NUM_SLOTS; i++)
      if (slot_elapsed[i*DUR_W +: DUR_W] > w_max_val) begin
        w_max_idx = IDX_W'(i);
        w_max_val = slot_elapsed[i*DUR_W +: DUR_W];
      end
  end

  assign available = 1'b1;
  assign target    = (|slot_done) ? w_rr_idx : w_max_idx;
`else
  logic w_unused_elapsed;
  assign w_unused_elapsed = ^slot_elapsed;
  assign available        = |slot_done;
  assign target           = w_rr_idx;
`endif
endmodule

// File: rtl/chord_scheduler.sv
// Accepts note requests and strobes them into free chord slots, one load per accepted request.
// Optional build macro: CHORD_STEAL_EN (steal the longest-running slot when none is done).
module chord_scheduler
  import chord_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  chord_scheduler_if.slave           req,
  input  logic [NUM_SLOTS-1:0]       slot_done,
  input  logic [DUR_W*NUM_SLOTS-1:0] slot_elapsed,
  output logic [NUM_SLOTS-1:0]       load_slot,
  output logic [NOTE_W-1:0]          load_note,
  output logic [DUR_W-1:0]           load_duration,
  output logic [CNT_W-1:0]           notes_issued
);
  localparam int IDX_W = $clog2(NUM_SLOTS);

  state_t            r_state, w_state_next;
  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_dur;
  logic [IDX_W-1:0]  r_target, r_rr_ptr;
  logic [CNT_W-1:0]  r_issued;
  logic [IDX_W-1:0]  w_target;
  logic              w_available, w_ready, w_accept, w_issue;

  chord_slot_picker #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) u_picker (
    .slot_done    (slot_done),
    .slot_elapsed (slot_elapsed),
    .rr_ptr       (r_rr_ptr),
    .target       (w_target),
    .available    (w_available)
  );

  assign w_ready       = !reset && (r_state == IDLE) && play_enable && w_available;
  assign w_accept      = req.req_valid && w_ready;
  assign w_issue       = !reset && (r_state == LOAD) && play_enable;
  assign req.req_ready = w_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_note   <= '0;
      r_dur    <= '0;
      r_target <= '0;
      r_rr_ptr <= '0;
      r_issued <= '0;
    end else begin
      if (w_accept) begin
        r_note   <= req.req_note;
        r_dur    <= req.req_duration;
        r_target <= w_target;
      end
      if (w_issue) begin
        r_rr_ptr <= (r_target == IDX_W'(NUM_SLOTS - 1)) ? '0 : r_target + IDX_W'(1);
        r_issued <= r_issued + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = LOAD;
      LOAD:    if (play_enable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Everything reads zero while reset is held, even before the registers clear.
  always_comb begin
    load_slot     = '0;
    if (w_issue) load_slot = NUM_SLOTS'(1) << r_target;
    load_note     = reset ? '0 : r_note;
    load_duration = reset ? '0 : r_dur;
    notes_issued  = reset ? '0 : r_issued;
  end
endmodule

// File: tb/tb_chord_scheduler.sv
// Self-checking bench for chord_scheduler: directed vector table, corner sequences, randomized model check.
module tb_chord_scheduler;
  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        reset, play_enable;
  logic [2:0]  slot_done;
  logic [17:0] slot_elapsed;
  logic [2:0]  load_slot;
  logic [5:0]  load_note, load_duration;
  logic [7:0]  notes_issued;
  int          checks = 0;
  int          failures = 0;

  chord_scheduler_if req_if();

  chord_scheduler #(.NUM_SLOTS(NS)) dut (
    .clk           (clk),
    .reset         (reset),
    .play_enable   (play_enable),
    .req           (req_if),
    .slot_done     (slot_done),
    .slot_elapsed  (slot_elapsed),
    .load_slot     (load_slot),
    .load_note     (load_note),
    .load_duration (load_duration),
    .notes_issued  (notes_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, pe, val;
    logic [5:0] note, dur;
    logic [2:0] done;
    logic       ex_ready;
    logic [2:0] ex_ls;
    logic [5:0] ex_ln, ex_ld;
    logic [7:0] ex_ni;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic p, logic v, logic [5:0] n, logic [5:0] d, logic [2:0] dn,
                              logic er, logic [2:0] els, logic [5:0] eln, logic [5:0] eld, logic [7:0] eni);
    vec_t t;
    t.rst = r; t.pe = p; t.val = v; t.note = n; t.dur = d; t.done = dn;
    t.ex_ready = er; t.ex_ls = els; t.ex_ln = eln; t.ex_ld = eld; t.ex_ni = eni;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic step(input logic r, input logic p, input logic v, input logic [5:0] n,
                      input logic [5:0] d, input logic [2:0] dn, input logic [17:0] el);
    @(negedge clk);
    reset = r; play_enable = p; req_if.req_valid = v; req_if.req_note = n;
    req_if.req_duration = d; slot_done = dn; slot_elapsed = el;
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] exp);
    logic [23:0] act;
    act = {req_if.req_ready, load_slot, load_note, load_duration, notes_issued};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ready/slot/note/dur/issued got=%b/%b/%0d/%0d/%0d want=%b/%b/%0d/%0d/%0d",
               name, act[23], act[22:20], act[19:14], act[13:8], act[7:0],
               exp[23], exp[22:20], exp[19:14], exp[13:8], exp[7:0]);
    end
  endtask

  // Reference model state: at most one pending request, a rotating pointer and a load counter.
  bit         m_pending;
  int         m_target, m_rr, m_cnt;
  logic [5:0] m_note, m_dur;

  function automatic int pick(logic [2:0] d, logic [17:0] e, int rr);
    int best;
    for (int k = 0; k < NS; k++)
      if (d[(rr + k) % NS]) return (rr + k) % NS;
    best = 0;
    for (int i = 1; i < NS; i++)
      if (e[i*6 +: 6] > e[best*6 +: 6]) best = i;
    return best;
  endfunction

  function automatic bit steal_on();
`ifdef CHORD_STEAL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic        r, p, v;
    logic [5:0]  n, d;
    logic [2:0]  dn;
    logic [17:0] el;
    logic        e_ready;
    logic [2:0]  e_ls;

    reset = 1'b1; play_enable = 1'b0; req_if.req_valid = 1'b0; req_if.req_note = '0;
    req_if.req_duration = '0; slot_done = '0; slot_elapsed = '0;
    repeat (2) @(negedge clk);

`ifndef CHORD_STEAL_EN
    tbl.push_back(mk(1,1,1,12,4,3'b111, 0,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,1,12,4,3'b111, 1,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,3'b111, 0,3'b001,12,4,0));
    tbl.push_back(mk(0,1,0, 0,0,3'b111, 1,3'b000,12,4,1));
    tbl.push_back(mk(1,1,0, 0,0,3'b111, 0,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,1,20,5,3'b111, 1,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,1,21,6,3'b111, 0,3'b001,20,5,0));
    tbl.push_back(mk(0,1,1,21,6,3'b111, 1,3'b000,20,5,1));
    tbl.push_back(mk(0,1,1,22,7,3'b111, 0,3'b010,21,6,1));
    tbl.push_back(mk(0,1,1,22,7,3'b111, 1,3'b000,21,6,2));
    tbl.push_back(mk(0,1,0, 0,0,3'b111, 0,3'b100,22,7,2));
    tbl.push_back(mk(0,1,1,30,3,3'b000, 0,3'b000,22,7,3));
    tbl.push_back(mk(0,1,1,30,3,3'b000, 0,3'b000,22,7,3));
    tbl.push_back(mk(0,1,1,30,3,3'b010, 1,3'b000,22,7,3));
    tbl.push_back(mk(0,1,0, 0,0,3'b000, 0,3'b010,30,3,3));
    tbl.push_back(mk(0,1,1,31,2,3'b011, 1,3'b000,30,3,4));
    tbl.push_back(mk(0,0,0, 0,0,3'b011, 0,3'b000,31,2,4));
    tbl.push_back(mk(0,0,0, 0,0,3'b011, 0,3'b000,31,2,4));
    tbl.push_back(mk(0,0,0, 0,0,3'b011, 0,3'b000,31,2,4));
    tbl.push_back(mk(0,1,0, 0,0,3'b011, 0,3'b001,31,2,4));
    tbl.push_back(mk(0,1,0, 0,0,3'b011, 1,3'b000,31,2,5));
    tbl.push_back(mk(0,0,1,40,1,3'b111, 0,3'b000,31,2,5));
    tbl.push_back(mk(0,1,1,40,1,3'b111, 1,3'b000,31,2,5));
    tbl.push_back(mk(1,1,0, 0,0,3'b111, 0,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,3'b111, 1,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,1, 9,0,3'b111, 1,3'b000, 0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,3'b111, 0,3'b001, 9,0,0));
    tbl.push_back(mk(0,1,0, 0,0,3'b111, 1,3'b000, 9,0,1));
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].pe, tbl[i].val, tbl[i].note, tbl[i].dur, tbl[i].done, '0);
      check($sformatf("vec%0d", i),
            {tbl[i].ex_ready, tbl[i].ex_ls, tbl[i].ex_ln, tbl[i].ex_ld, tbl[i].ex_ni});
      $display("vec %0d rst=%b pe=%b valid=%b done=%b -> ready=%b load_slot=%b issued=%0d",
               i, tbl[i].rst, tbl[i].pe, tbl[i].val, tbl[i].done, req_if.req_ready, load_slot, notes_issued);
    end
`else
    step(1, 1, 0, 0, 0, 3'b000, '0);
    step(0, 1, 1, 7, 3, 3'b000, {6'd9, 6'd9, 6'd5});
    check("steal_ready", {1'b1, 3'b000, 6'd0, 6'd0, 8'd0});
    step(0, 1, 0, 0, 0, 3'b000, {6'd9, 6'd9, 6'd5});
    check("steal_load", {1'b0, 3'b010, 6'd7, 6'd3, 8'd0});
    $display("steal: elapsed {5,9,9} -> load_slot=%b", load_slot);
`endif

    // 256 loads from reset must wrap the issue counter back to zero.
    step(1, 1, 0, 0, 0, 3'b111, '0);
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 1, 6'(i), 6'(i), 3'b111, '0);
      if (i == 255) check("issued_255", {1'b1, 3'b000, 6'd62, 6'd62, 8'd255});
      step(0, 1, 1, 6'(i), 6'(i), 3'b111, '0);
    end
    step(0, 1, 0, 0, 0, 3'b111, '0);
    check("issued_wrap", {1'b1, 3'b000, 6'd63, 6'd63, 8'd0});
    $display("wrap: 256 loads -> notes_issued=%0d", notes_issued);

    // Randomized run against the model, starting from a reset cycle.
    for (int c = 0; c < 800; c++) begin
      r  = (c == 0) || ($urandom_range(0, 49) == 0);
      p  = ($urandom_range(0, 9) < 8);
      v  = ($urandom_range(0, 9) < 6);
      n  = 6'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      dn = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      el = 18'($urandom);
      step(r, p, v, n, d, dn, el);

      e_ready = !r && !m_pending && p && ((dn != 0) || steal_on());
      e_ls    = (!r && m_pending && p) ? 3'(1 << m_target) : 3'b000;
      check($sformatf("rand%0d", c),
            {e_ready, e_ls, r ? 6'd0 : m_note, r ? 6'd0 : m_dur, r ? 8'd0 : 8'(m_cnt)});
      $display("rand %0d rst=%b pe=%b valid=%b done=%b -> ready=%b load_slot=%b issued=%0d",
               c, r, p, v, dn, req_if.req_ready, load_slot, notes_issued);

      if (r) begin
        m_pending = 0; m_target = 0; m_rr = 0; m_cnt = 0; m_note = '0; m_dur = '0;
      end else if (m_pending && p) begin
        m_pending = 0;
        m_cnt     = (m_cnt + 1) % 256;
        m_rr      = (m_target + 1) % NS;
      end else if (e_ready && v) begin
        m_pending = 1;
        m_target  = pick(dn, el, m_rr);
        m_note    = n;
        m_dur     = d;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
